// File: rtl/motor_plant_model_pkg.sv
// Shared types and constants for the rotor plant model: default widths, rpm bound
// and the motor channel index map.
package motor_plant_model_pkg;

    localparam int DW_DEF = 16;

    typedef logic signed [DW_DEF-1:0] rpm_t;

    localparam int MOT_L  = 0;
    localparam int MOT_R  = 1;
    localparam int MOT_F  = 2;
    localparam int MOT_RV = 3;

    localparam logic [DW_DEF-1:0] RPM_MAX_DEF = 16'h157C;

endpackage

// File: rtl/motor_plant_model_if.sv
// Controller-to-plant bundle: step enable, commands and stall faults in; modelled rpm,
// saturation flags and settle status out. The plant takes the slave side.
interface motor_plant_model_if #(
    parameter int NUM_MOT = 4,
    parameter int DW      = 16
);

    logic                         en;
    logic [NUM_MOT-1:0][DW-1:0]   mot_set;
    logic [NUM_MOT-1:0]           fault_stall;
    logic [NUM_MOT-1:0][DW-1:0]   rpm_sense;
    logic [NUM_MOT-1:0]           sat_hi;
    logic [NUM_MOT-1:0]           sat_lo;
    logic [NUM_MOT-1:0]           settled;

    modport master (
        output en, mot_set, fault_stall,
        input  rpm_sense, sat_hi, sat_lo, settled
    );

    modport slave (
        input  en, mot_set, fault_stall,
        output rpm_sense, sat_hi, sat_lo, settled
    );

endinterface

// File: rtl/motor_plant_model_channel.sv
// One rotor channel: transport delay line, scaled integrator clamped to [0, RPM_MAX],
// locked-rotor fault and settle detector. PLANT_DRAG_EN adds a first-order drag term.
module motor_plant_model_channel
    import motor_plant_model_pkg::*;
#(
    parameter int              DW         = DW_DEF,
    parameter int              GAIN_SHIFT = 3,
    parameter int              DELAY      = 1,
    parameter logic [DW-1:0]   RPM_MAX    = RPM_MAX_DEF,
    parameter int              SETTLE_WIN = 4,
    parameter int              SETTLE_CYC = 16,
    parameter int              DRAG_SHIFT = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en_i,
    input  logic signed [DW-1:0] motSet_i,
    input  logic                 faultStall_i,
    output logic signed [DW-1:0] rpmSense_o,
    output logic                 satHi_o,
    output logic                 satLo_o,
    output logic                 settled_o
);

    localparam int SW = DW + 2;
    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam logic signed [SW-1:0] RPM_MAX_W = SW'(RPM_MAX);

    logic signed [DW-1:0] dl_q [DELAY];
    logic signed [DW-1:0] dl_d [DELAY];
    logic signed [DW-1:0] rpm_q, rpm_d;
    logic                 satHi_q, satHi_d;
    logic                 satLo_q, satLo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] delta;

    // The delay line keeps shifting during a stall, so released channels resume
    // integrating whatever commands were in flight.
    always_comb begin
        dl_d    = dl_q;
        rpm_d   = rpm_q;
        satHi_d = satHi_q;
        satLo_d = satLo_q;
        cnt_d   = cnt_q;
        sum     = '0;
        delta   = '0;
        if (en_i) begin
            dl_d[0] = motSet_i >>> GAIN_SHIFT;
            for (int i = 1; i < DELAY; i++) begin
                dl_d[i] = dl_q[i-1];
            end
            sum = SW'(rpm_q) + SW'(dl_q[DELAY-1]);
`ifdef PLANT_DRAG_EN
            sum = sum - SW'(rpm_q >>> DRAG_SHIFT);
`endif
            if (faultStall_i) begin
                rpm_d   = '0;
                satHi_d = 1'b0;
                satLo_d = 1'b0;
                cnt_d   = '0;
            end else begin
                if (sum > RPM_MAX_W) begin
                    rpm_d   = RPM_MAX;
                    satHi_d = 1'b1;
                    satLo_d = 1'b0;
                end else if (sum < 0) begin
                    rpm_d   = '0;
                    satHi_d = 1'b0;
                    satLo_d = 1'b1;
                end else begin
                    rpm_d   = sum[DW-1:0];
                    satHi_d = 1'b0;
                    satLo_d = 1'b0;
                end
                // Delta is taken after clamping, so a channel pinned at a bound settles.
                delta = SW'(rpm_d) - SW'(rpm_q);
                if (delta < 0) begin
                    delta = -delta;
                end
                if (delta <= SW'(SETTLE_WIN)) begin
                    cnt_d = (cnt_q >= CW'(SETTLE_CYC)) ? cnt_q : cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DELAY; i++) begin
                dl_q[i] <= '0;
            end
            rpm_q   <= '0;
            satHi_q <= 1'b0;
            satLo_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            dl_q    <= dl_d;
            rpm_q   <= rpm_d;
            satHi_q <= satHi_d;
            satLo_q <= satLo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rpmSense_o = rpm_q;
    assign satHi_o    = satHi_q;
    assign satLo_o    = satLo_q;
    assign settled_o  = (cnt_q >= CW'(SETTLE_CYC));

endmodule

// File: rtl/motor_plant_model.sv
// N-channel rotor plant for closed-loop sims and HIL; channels are fully independent.
// Optional first-order drag is enabled by defining PLANT_DRAG_EN.
module motor_plant_model
    import motor_plant_model_pkg::*;
#(
    parameter int              NUM_MOT    = 4,
    parameter int              DW         = DW_DEF,
    parameter int              GAIN_SHIFT = 3,
    parameter int              DELAY      = 1,
    parameter logic [DW-1:0]   RPM_MAX    = RPM_MAX_DEF,
    parameter int              SETTLE_WIN = 4,
    parameter int              SETTLE_CYC = 16,
    parameter int              DRAG_SHIFT = 6
) (
    input  logic              clk,
    input  logic              resetn,
    motor_plant_model_if.slave plant
);

    logic [NUM_MOT-1:0][DW-1:0] rpmArr;
    logic [NUM_MOT-1:0]         satHiArr;
    logic [NUM_MOT-1:0]         satLoArr;
    logic [NUM_MOT-1:0]         settledArr;

    for (genvar g = 0; g < NUM_MOT; g++) begin : gCh
        motor_plant_model_channel #(
            .DW         (DW),
            .GAIN_SHIFT (GAIN_SHIFT),
            .DELAY      (DELAY),
            .RPM_MAX    (RPM_MAX),
            .SETTLE_WIN (SETTLE_WIN),
            .SETTLE_CYC (SETTLE_CYC),
            .DRAG_SHIFT (DRAG_SHIFT)
        ) uChannel (
            .clk          (clk),
            .resetn       (resetn),
            .en_i         (plant.en),
            .motSet_i     (plant.mot_set[g]),
            .faultStall_i (plant.fault_stall[g]),
            .rpmSense_o   (rpmArr[g]),
            .satHi_o      (satHiArr[g]),
            .satLo_o      (satLoArr[g]),
            .settled_o    (settledArr[g])
        );
    end

    assign plant.rpm_sense = rpmArr;
    assign plant.sat_hi    = satHiArr;
    assign plant.sat_lo    = satLoArr;
    assign plant.settled   = settledArr;

endmodule

// File: tb/tb_motor_plant_model.sv
// Randomised bench for motor_plant_model against an arithmetic per-channel plant model.
// Honours PLANT_DRAG_EN so the model tracks whichever build is compiled.
module tb_motor_plant_model;
    import motor_plant_model_pkg::*;

    localparam int NM      = 4;
    localparam int DLY     = 1;
    localparam int RMAX    = 5500;
    localparam int WIN     = 4;
    localparam int NCYC    = 16;

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    motor_plant_model_if #(.NUM_MOT(NM), .DW(16)) pif ();

    motor_plant_model #(.NUM_MOT(NM), .DELAY(DLY)) dut (
        .clk    (clk),
        .resetn (resetn),
        .plant  (pif)
    );

    always #5 clk = ~clk;

    // Reference plant: commands in flight are a queue, rpm is a plain integer.
    int mRpm [NM];
    int mCnt [NM];
    bit mHi  [NM];
    bit mLo  [NM];
    int mPipe [NM][$];

    task automatic mdlReset();
        for (int c = 0; c < NM; c++) begin
            mRpm[c] = 0;
            mCnt[c] = 0;
            mHi[c]  = 0;
            mLo[c]  = 0;
            mPipe[c] = {};
            for (int k = 0; k < DLY; k++) mPipe[c].push_back(0);
        end
    endtask

    task automatic mdlStep();
        int oldR, tail, cmd, sum, newR, d;
        if (pif.en) begin
            for (int c = 0; c < NM; c++) begin
                oldR = mRpm[c];
                cmd  = int'($signed(pif.mot_set[c])) >>> 3;
                tail = mPipe[c].pop_back();
                mPipe[c].push_front(cmd);
                if (pif.fault_stall[c]) begin
                    mRpm[c] = 0; mHi[c] = 0; mLo[c] = 0; mCnt[c] = 0;
                end else begin
                    sum = oldR + tail;
`ifdef PLANT_DRAG_EN
                    sum = sum - (oldR >>> 6);
`endif
                    mHi[c] = (sum > RMAX);
                    mLo[c] = (sum < 0);
                    newR   = (sum > RMAX) ? RMAX : ((sum < 0) ? 0 : sum);
                    d      = (newR > oldR) ? newR - oldR : oldR - newR;
                    mCnt[c] = (d <= WIN) ? ((mCnt[c] < NCYC) ? mCnt[c] + 1 : NCYC) : 0;
                    mRpm[c] = newR;
                end
            end
        end
    endtask

    function automatic logic [NM*16-1:0] expRpm();
        logic [NM*16-1:0] r;
        for (int c = 0; c < NM; c++) r[c*16 +: 16] = 16'(mRpm[c]);
        return r;
    endfunction

    function automatic logic [3*NM-1:0] expFlags();
        logic [NM-1:0] h, l, s;
        for (int c = 0; c < NM; c++) begin
            h[c] = mHi[c];
            l[c] = mLo[c];
            s[c] = (mCnt[c] >= NCYC);
        end
        return {h, l, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (resetn) mdlStep();
        #1;
    endtask

    task automatic applyReset();
        resetn = 1'b0;
        #2;
        mdlReset();
        resetn = 1'b1;
    endtask

    task automatic applyStimulus(input int c, input int v);
        pif.mot_set[c] = 16'(v);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        pif.en = 1'b1;
        pif.fault_stall = '0;
        for (int c = 0; c < NM; c++) applyStimulus(c, 800 + 100 * c);
        mdlReset();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({pif.rpm_sense, pif.sat_hi, pif.sat_lo, pif.settled} !== '0) begin
                bad++;
                $display("[TB] FAIL reset_hold: got %h, want all zero",
                         {pif.rpm_sense, pif.sat_hi, pif.sat_lo, pif.settled});
            end
        end
        for (int c = 0; c < NM; c++) applyStimulus(c, 0);
        resetn = 1'b1;
    endtask

    task automatic test_ramp_clamp();
        applyReset();
        applyStimulus(MOT_L, 800);
        for (int i = 1; i <= 80; i++) begin
            tick();
            total++;
            if (pif.rpm_sense !== expRpm()) begin
                bad++;
                $display("[TB] FAIL ramp_rpm edge %0d: got %h want %h", i, pif.rpm_sense, expRpm());
            end
            total++;
            if ({pif.sat_hi, pif.sat_lo, pif.settled} !== expFlags()) begin
                bad++;
                $display("[TB] FAIL ramp_flags edge %0d: got %h want %h", i,
                         {pif.sat_hi, pif.sat_lo, pif.settled}, expFlags());
            end
            if (i == 2 || i == 56) begin
                total++;
                if (pif.rpm_sense[MOT_L] !== ((i == 2) ? 16'd100 : 16'h157C)) begin
                    bad++;
                    $display("[TB] FAIL ramp_point edge %0d: got %0d", i, pif.rpm_sense[MOT_L]);
                end
            end
        end
        total++;
        if (pif.sat_hi[MOT_L] !== 1'b1 || pif.settled[MOT_L] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL clamp_settled: sat_hi=%b settled=%b want 1 1",
                     pif.sat_hi[MOT_L], pif.settled[MOT_L]);
        end
    endtask

    task automatic test_floor();
        applyReset();
        applyStimulus(MOT_L, 800);
        for (int i = 0; i < 12; i++) begin
            if (i == 4) applyStimulus(MOT_L, -800);
            tick();
            total++;
            if ({pif.rpm_sense, pif.sat_hi, pif.sat_lo, pif.settled} !== {expRpm(), expFlags()}) begin
                bad++;
                $display("[TB] FAIL floor step %0d: got %h want %h", i,
                         {pif.rpm_sense, pif.sat_hi, pif.sat_lo, pif.settled}, {expRpm(), expFlags()});
            end
        end
        total++;
        if (pif.rpm_sense[MOT_L] !== 16'd0 || pif.sat_lo[MOT_L] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL floor_end: rpm=%0d sat_lo=%b want 0 1",
                     pif.rpm_sense[MOT_L], pif.sat_lo[MOT_L]);
        end
    endtask

    task automatic test_stall();
        applyReset();
        applyStimulus(0, 800); applyStimulus(1, 400); applyStimulus(2, 1200); applyStimulus(3, 240);
        for (int i = 0; i < 24; i++) begin
            pif.fault_stall[MOT_F] = (i >= 10 && i < 13);
            tick();
            total++;
            if ({pif.rpm_sense, pif.sat_hi, pif.sat_lo, pif.settled} !== {expRpm(), expFlags()}) begin
                bad++;
                $display("[TB] FAIL stall step %0d: got %h want %h", i,
                         {pif.rpm_sense, pif.sat_hi, pif.sat_lo, pif.settled}, {expRpm(), expFlags()});
            end
            if (i == 10) begin
                total++;
                if (pif.rpm_sense[MOT_F] !== 16'd0 || pif.settled[MOT_F] !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL stall_zero: rpm=%0d settled=%b want 0 0",
                             pif.rpm_sense[MOT_F], pif.settled[MOT_F]);
                end
            end
        end
        pif.fault_stall = '0;
    endtask

    task automatic test_freeze();
        pif.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < NM; c++) applyStimulus(c, int'($urandom_range(4000)) - 2000);
            pif.fault_stall = 4'($urandom);
            tick();
            total++;
            if ({pif.rpm_sense, pif.sat_hi, pif.sat_lo, pif.settled} !== {expRpm(), expFlags()}) begin
                bad++;
                $display("[TB] FAIL freeze step %0d: got %h want %h", i,
                         {pif.rpm_sense, pif.sat_hi, pif.sat_lo, pif.settled}, {expRpm(), expFlags()});
            end
        end
        pif.fault_stall = '0;
        pif.en = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < NM; c++) applyStimulus(c, 640);
        for (int i = 0; i < 6; i++) tick();
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if ({pif.rpm_sense, pif.sat_hi, pif.sat_lo, pif.settled} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_mid: got %h want all zero",
                     {pif.rpm_sense, pif.sat_hi, pif.sat_lo, pif.settled});
        end
        mdlReset();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (pif.rpm_sense !== expRpm()) begin
                bad++;
                $display("[TB] FAIL reset_resume %0d: got %h want %h", i, pif.rpm_sense, expRpm());
            end
        end
    endtask

    task automatic test_random();
        int hold [NM];
        applyReset();
        for (int c = 0; c < NM; c++) hold[c] = 0;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NM; c++) begin
                if (hold[c] == 0) begin
                    case ($urandom_range(3))
                        0: applyStimulus(c, 0);
                        1: applyStimulus(c, int'($urandom_range(2400)) - 1200);
                        2: applyStimulus(c, int'($urandom_range(65535)) - 32768);
                        default: applyStimulus(c, int'($urandom_range(40)) - 20);
                    endcase
                    hold[c] = int'($urandom_range(40, 1));
                end
                hold[c]--;
                pif.fault_stall[c] = ($urandom_range(99) < 3);
            end
            pif.en = ($urandom_range(99) >= 5);
            tick();
            total++;
            if (pif.rpm_sense !== expRpm()) begin
                bad++;
                $display("[TB] FAIL random_rpm %0d: got %h want %h", i, pif.rpm_sense, expRpm());
            end
            total++;
            if ({pif.sat_hi, pif.sat_lo, pif.settled} !== expFlags()) begin
                bad++;
                $display("[TB] FAIL random_flags %0d: got %h want %h", i,
                         {pif.sat_hi, pif.sat_lo, pif.settled}, expFlags());
            end
        end
        pif.en = 1'b1;
        pif.fault_stall = '0;
    endtask

    initial begin
        resetn = 1'b0;
        pif.en = 1'b0;
        pif.mot_set = '0;
        pif.fault_stall = '0;
        mdlReset();
        test_reset();
        test_ramp_clamp();
        test_floor();
        test_stall();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
